// File: rtl/priority_encoder8.sv
// Sequential 8-to-3 priority encoder: latches request pulses into a pending
// register and offers the highest pending index under a valid/ready handshake.

module pe_lane #(
    parameter int IDX    = 0,
    parameter int CODE_W = 3
) (
    input  logic              pend,
    input  logic              set,
    input  logic              acc,
    input  logic [CODE_W-1:0] code,
    output logic              p_nxt,
    output logic              lost
);
    logic clr;

    assign clr   = acc && (code == CODE_W'(IDX));
    // set wins over clear so a re-arriving request is re-presented, not dropped
    assign p_nxt = (pend & ~clr) | set;
    assign lost  = set & pend & ~clr;
endmodule

module priority_encoder8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       ovf
);
    localparam int NUM_LANES = 8;
    localparam int CODE_W    = 3;

    logic                 acc;
    logic [NUM_LANES-1:0] set;
    logic [NUM_LANES-1:0] p_nxt;
    logic [NUM_LANES-1:0] lost;
    logic [CODE_W-1:0]    code_nxt;

    assign acc = valid & ready;
    assign set = en ? req : '0;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        pe_lane #(.IDX(k), .CODE_W(CODE_W)) u_lane (
            .pend  (pending[k]),
            .set   (set[k]),
            .acc   (acc),
            .code  (code),
            .p_nxt (p_nxt[k]),
            .lost  (lost[k])
        );
    end

    // Highest set bit wins; an empty vector yields 0.
    always_comb begin
        code_nxt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (p_nxt[i]) code_nxt = CODE_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            pending <= p_nxt;
            ovf     <= |lost;
            // an offered code is frozen until the consumer takes it
            if (!valid || acc) begin
                valid <= |p_nxt;
                code  <= code_nxt;
            end
        end
    end
endmodule

// File: tb/tb_priority_encoder8.sv
// Directed bench for priority_encoder8 with a scoreboard of expected codes,
// popped whenever a code is accepted (valid & ready at a rising edge).

module tb_priority_encoder8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    priority_encoder8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .ready   (ready),
        .code    (code),
        .valid   (valid),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pre-edge: a handshake about to complete pops the scoreboard.
    task automatic tick();
        logic [2:0] e;
        if (valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected observed=%0d expected=none", code);
            end else begin
                e = exp_q.pop_front();
                chk("sb_code", {5'd0, code}, {5'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req = 8'hFF; ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pending", pending, 8'h00);
        chk("rst_valid", {7'd0, valid}, 8'h00);
        chk("rst_code", {5'd0, code}, 8'h00);
        chk("rst_ovf", {7'd0, ovf}, 8'h00);
        rst_n = 1'b1; req = 8'h00;
        tick();
        chk("post_rst_pending", pending, 8'h00);
        chk("post_rst_valid", {7'd0, valid}, 8'h00);

        // single request sweep, en=0 first must capture nothing
        for (int s = 0; s < 8; s++) begin
            en = 1'b0; req = 8'(1 << s); ready = 1'b1;
            tick();
            chk("sweep_en0_pending", pending, 8'h00);
            chk("sweep_en0_valid", {7'd0, valid}, 8'h00);
            en = 1'b1;
            exp_q.push_back(3'(s));
            tick();
            req = 8'h00;
            chk("sweep_valid", {7'd0, valid}, 8'h01);
            chk("sweep_code", {5'd0, code}, 8'(s));
            chk("sweep_pending", pending, 8'(1 << s));
            tick();
            chk("sweep_done_valid", {7'd0, valid}, 8'h00);
            chk("sweep_done_pending", pending, 8'h00);
        end

        // priority drain A5 -> 7,5,2,0
        req = 8'hA5; ready = 1'b1;
        exp_q.push_back(3'd7); exp_q.push_back(3'd5);
        exp_q.push_back(3'd2); exp_q.push_back(3'd0);
        tick(); req = 8'h00;
        chk("drain_p0", pending, 8'hA5); chk("drain_c0", {5'd0, code}, 8'd7);
        tick();
        chk("drain_p1", pending, 8'h25); chk("drain_c1", {5'd0, code}, 8'd5);
        tick();
        chk("drain_p2", pending, 8'h05); chk("drain_c2", {5'd0, code}, 8'd2);
        tick();
        chk("drain_p3", pending, 8'h01); chk("drain_c3", {5'd0, code}, 8'd0);
        tick();
        chk("drain_p4", pending, 8'h00); chk("drain_valid", {7'd0, valid}, 8'h00);

        // stall: code 0 held while 7 arrives
        ready = 1'b0; req = 8'h01; exp_q.push_back(3'd0);
        tick();
        chk("stall_code", {5'd0, code}, 8'd0); chk("stall_valid", {7'd0, valid}, 8'h01);
        req = 8'h80; exp_q.push_back(3'd7);
        tick(); req = 8'h00;
        chk("stall_hold_code", {5'd0, code}, 8'd0);
        chk("stall_pending", pending, 8'h81);
        chk("stall_ovf", {7'd0, ovf}, 8'h00);
        ready = 1'b1;
        tick();
        chk("stall_next_code", {5'd0, code}, 8'd7); chk("stall_next_pending", pending, 8'h80);
        tick();
        chk("stall_done_valid", {7'd0, valid}, 8'h00);

        // overflow on repeated request while stalled
        ready = 1'b0; req = 8'h08; exp_q.push_back(3'd3);
        tick();
        chk("ovf_first", {7'd0, ovf}, 8'h00); chk("ovf_code", {5'd0, code}, 8'd3);
        tick();
        chk("ovf_second", {7'd0, ovf}, 8'h01); chk("ovf_pending", pending, 8'h08);
        req = 8'h00;
        tick();
        chk("ovf_clear", {7'd0, ovf}, 8'h00);
        // collision: request on the accepting cycle re-presents, no ovf
        ready = 1'b1; req = 8'h08; exp_q.push_back(3'd3);
        tick(); req = 8'h00;
        chk("coll_ovf", {7'd0, ovf}, 8'h00);
        chk("coll_valid", {7'd0, valid}, 8'h01);
        chk("coll_code", {5'd0, code}, 8'd3);
        chk("coll_pending", pending, 8'h08);
        tick();
        chk("coll_done_valid", {7'd0, valid}, 8'h00);

        // async reset mid-drain
        ready = 1'b1; req = 8'hFF;
        for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
        tick(); req = 8'h00;
        tick();
        chk("ar_code", {5'd0, code}, 8'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pending", pending, 8'h00);
        chk("ar_valid", {7'd0, valid}, 8'h00);
        chk("ar_code0", {5'd0, code}, 8'h00);
        chk("ar_ovf", {7'd0, ovf}, 8'h00);
        exp_q.delete();
        #1 rst_n = 1'b1;
        tick();
        chk("ar_post_valid", {7'd0, valid}, 8'h00);
        chk("ar_post_pending", pending, 8'h00);
        tick();
        chk("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
